// File: rtl/full_adder_pkg.sv
// Shared types and constants for the ripple-carry adder slice.
// Holds no logic; the default width and the half-adder result type live here.
package full_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  typedef struct packed {
    logic s;
    logic c;
  } ha_out_t;

endpackage

// File: rtl/full_adder_if.sv
// Operand and result bundle for full_adder.
// The master drives the operands; the slave returns combinational and registered results.
interface full_adder_if
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  modport master (
    output x, y, cin,
    input  sum, carry, sum_q, carry_q
  );

  modport slave (
    input  x, y, cin,
    output sum, carry, sum_q, carry_q
  );

endinterface

// File: rtl/full_adder_half_adder.sv
// Single-bit half adder leaf cell: s = a ^ b, c = a & b.
// Purely combinational, zero latency, no flow control.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder from two half adders per bit: combinational {carry,sum}
// plus a one-cycle registered copy; no enable or handshake, the register always loads.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  full_adder_if.slave  bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  ha_out_t ha0 [WIDTH];
  ha_out_t ha1 [WIDTH];

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha0 (
      .a (bus.x[i]),
      .b (bus.y[i]),
      .s (ha0[i].s),
      .c (ha0[i].c)
    );

    half_adder u_ha1 (
      .a (ha0[i].s),
      .b (c[i]),
      .s (ha1[i].s),
      .c (ha1[i].c)
    );

    // At most one of the two half-adder carries can be set, so OR merges them exactly.
    assign sum_d[i] = ha1[i].s;
    assign c[i+1]   = ha0[i].c | ha1[i].c;
  end

  assign carry_d = c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.sum     = sum_d;
  assign bus.carry   = carry_d;
  assign bus.sum_q   = sum_q;
  assign bus.carry_q = carry_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH 1, 4 and 8.
module tb_full_adder;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(4)) if4 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  full_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  full_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.x = '0; if1.y = '0; if1.cin = 1'b0;
    if4.x = '0; if4.y = '0; if4.cin = 1'b0;
    if8.x = '0; if8.y = '0; if8.cin = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({if1.carry_q, if1.sum_q} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_w1 got=%b want=00", {if1.carry_q, if1.sum_q});
    end
    n_vec++;
    if ({if4.carry_q, if4.sum_q} !== 5'h00) begin
      n_fail++;
      $display("FAIL reset_w4 got=%h want=00", {if4.carry_q, if4.sum_q});
    end
    n_vec++;
    if ({if8.carry_q, if8.sum_q} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_w8 got=%h want=000", {if8.carry_q, if8.sum_q});
    end
  endtask

  task automatic test_w1_truth();
    logic [1:0] exp [8];
    logic [2:0] v;
    exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i > 0) begin
        n_vec++;
        if ({if1.carry_q, if1.sum_q} !== exp[i-1]) begin
          n_fail++;
          $display("FAIL w1_reg[%0d] got=%b want=%b", i - 1, {if1.carry_q, if1.sum_q}, exp[i-1]);
        end
      end
      v = 3'(i);
      if1.x = v[2]; if1.y = v[1]; if1.cin = v[0];
      #1;
      n_vec++;
      if ({if1.carry, if1.sum} !== exp[i]) begin
        n_fail++;
        $display("FAIL w1_comb[%0d] got=%b want=%b", i, {if1.carry, if1.sum}, exp[i]);
      end
    end
    tick();
    n_vec++;
    if ({if1.carry_q, if1.sum_q} !== 2'b11) begin
      n_fail++;
      $display("FAIL w1_reg[7] got=%b want=11", {if1.carry_q, if1.sum_q});
    end
  endtask

  task automatic test_w1_reset();
    if1.x = 1'b1; if1.y = 1'b1; if1.cin = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if ({if1.carry_q, if1.sum_q} !== 2'b00) begin
        n_fail++;
        $display("FAIL w1_rst_reg[%0d] got=%b want=00", i, {if1.carry_q, if1.sum_q});
      end
      n_vec++;
      if ({if1.carry, if1.sum} !== 2'b11) begin
        n_fail++;
        $display("FAIL w1_rst_comb[%0d] got=%b want=11", i, {if1.carry, if1.sum});
      end
    end
    rst = 1'b0;
    if1.x = 1'b1; if1.y = 1'b0; if1.cin = 1'b1;
    tick();
    n_vec++;
    if ({if1.carry_q, if1.sum_q} !== 2'b10) begin
      n_fail++;
      $display("FAIL w1_release got=%b want=10", {if1.carry_q, if1.sum_q});
    end
  endtask

  task automatic test_w4_vectors();
    if4.x = 4'hF; if4.y = 4'h0; if4.cin = 1'b1;
    #1;
    n_vec++;
    if ({if4.carry, if4.sum} !== 5'h10) begin
      n_fail++;
      $display("FAIL w4_wrap got=%h want=10", {if4.carry, if4.sum});
    end
    tick();
    n_vec++;
    if ({if4.carry_q, if4.sum_q} !== 5'h10) begin
      n_fail++;
      $display("FAIL w4_wrap_reg got=%h want=10", {if4.carry_q, if4.sum_q});
    end
    if4.x = 4'h7; if4.y = 4'h8; if4.cin = 1'b0;
    #1;
    n_vec++;
    if ({if4.carry, if4.sum} !== 5'h0F) begin
      n_fail++;
      $display("FAIL w4_nocarry got=%h want=0f", {if4.carry, if4.sum});
    end
    tick();
    n_vec++;
    if ({if4.carry_q, if4.sum_q} !== 5'h0F) begin
      n_fail++;
      $display("FAIL w4_nocarry_reg got=%h want=0f", {if4.carry_q, if4.sum_q});
    end
  endtask

  task automatic test_w4_reset_mid();
    logic [4:0] want_q [3];
    want_q = '{5'h12, 5'h00, 5'h12};
    if4.x = 4'h9; if4.y = 4'h9; if4.cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rst = (i == 1);
      tick();
      n_vec++;
      if ({if4.carry_q, if4.sum_q} !== want_q[i]) begin
        n_fail++;
        $display("FAIL w4_mid_reg[%0d] got=%h want=%h", i, {if4.carry_q, if4.sum_q}, want_q[i]);
      end
      n_vec++;
      if ({if4.carry, if4.sum} !== 5'h12) begin
        n_fail++;
        $display("FAIL w4_mid_comb[%0d] got=%h want=12", i, {if4.carry, if4.sum});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_w8_random();
    logic [8:0] exp;
    logic [8:0] prev;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    prev = 9'h000;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i > 0) begin
        n_vec++;
        if ({if8.carry_q, if8.sum_q} !== prev) begin
          n_fail++;
          $display("FAIL w8_reg[%0d] got=%h want=%h", i, {if8.carry_q, if8.sum_q}, prev);
        end
      end
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      if8.x = a; if8.y = b; if8.cin = ci;
      exp = {1'b0, a} + {1'b0, b} + {8'h00, ci};
      #1;
      n_vec++;
      if ({if8.carry, if8.sum} !== exp) begin
        n_fail++;
        $display("FAIL w8_comb[%0d] x=%h y=%h cin=%b got=%h want=%h", i, a, b, ci, {if8.carry, if8.sum}, exp);
      end
      prev = exp;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    test_reset();
    test_w1_truth();
    test_w1_reset();
    test_w4_vectors();
    test_w4_reset_mid();
    test_w8_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
